// File: rtl/dcache_axi_bridge_if.sv
// Bundled signals between the data cache, the bridge and the AXI slave.
// The master modport is the bridge's view; slave is the cache and AXI slave side.
interface dcache_axi_bridge_if #(
    parameter int ID_WIDTH = 4
);
    // Cache-side SRAM-like port
    logic                req;
    logic                wr;
    logic [1:0]          size;
    logic [31:0]         addr;
    logic [31:0]         wdata;
    logic [31:0]         rdata;
    logic                addr_ok;
    logic                data_ok;
    logic                err;

    // AXI read channels
    logic [ID_WIDTH-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;
    logic [31:0]         rdata_axi;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    // AXI write channels
    logic [ID_WIDTH-1:0] awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [31:0]         wdata_axi;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok, err,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata_axi, rresp, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata_axi, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok, err,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata_axi, rresp, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata_axi, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/dcache_axi_bridge.sv
// Data-cache to AXI bridge: turns single-beat SRAM-like requests into one
// outstanding single-beat AXI read or write transaction.
module dcache_axi_bridge #(
    parameter int ID_WIDTH = 4,
    parameter int RD_ID    = 0,
    parameter int WR_ID    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    dcache_axi_bridge_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WREQ,
        WRESP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [31:0] r_wdata;
    logic [3:0]  r_strb;
    logic        r_wr;
    logic        r_aw_done;
    logic        r_w_done;

    logic        w_accept;
    logic        w_addr_ok;
    logic        w_data_ok;
    logic        w_err;
    logic        w_arvalid;
    logic        w_rready;
    logic        w_awvalid;
    logic        w_wvalid;
    logic        w_bready;
    logic        w_aw_hs;
    logic        w_w_hs;

    function automatic logic [3:0] f_strb(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] strb;
        case (size)
            2'b00:   strb = 4'b0001 << lane;
            2'b01:   strb = lane[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // A size code of 11 is carried as a word so AxSIZE never exceeds 010
    function automatic logic [1:0] f_size(input logic [1:0] size);
        return (size == 2'b11) ? 2'b10 : size;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_size    <= '0;
            r_wdata   <= '0;
            r_strb    <= '0;
            r_wr      <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= bus.addr;
                r_size  <= f_size(bus.size);
                r_wdata <= bus.wdata;
                r_strb  <= f_strb(bus.size, bus.addr[1:0]);
                r_wr    <= bus.wr;
            end
            if (w_aw_hs) begin
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_done <= 1'b1;
            end
            if (r_state == WREQ && w_next == WRESP) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
        end
    end

    // Outputs are forced low while rst is high so nothing leaks out mid-reset
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_addr_ok = 1'b0;
        w_data_ok = 1'b0;
        w_err     = 1'b0;
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        w_awvalid = 1'b0;
        w_wvalid  = 1'b0;
        w_bready  = 1'b0;
        w_aw_hs   = 1'b0;
        w_w_hs    = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    w_addr_ok = bus.req;
                    w_accept  = bus.req;
                    if (bus.req) begin
                        w_next = bus.wr ? WREQ : RADDR;
                    end
                end
                RADDR: begin
                    w_arvalid = 1'b1;
                    if (bus.arready) begin
                        w_next = RDATA;
                    end
                end
                RDATA: begin
                    w_rready = 1'b1;
                    if (bus.rvalid) begin
                        w_data_ok = 1'b1;
                        w_err     = (bus.rresp != 2'b00);
                        w_next    = IDLE;
                    end
                end
                WREQ: begin
                    w_awvalid = !r_aw_done;
                    w_wvalid  = !r_w_done;
                    w_aw_hs   = w_awvalid & bus.awready;
                    w_w_hs    = w_wvalid & bus.wready;
                    if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                        w_next = WRESP;
                    end
                end
                WRESP: begin
                    w_bready = 1'b1;
                    if (bus.bvalid) begin
                        w_data_ok = 1'b1;
                        w_err     = (bus.bresp != 2'b00);
                        w_next    = IDLE;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    assign bus.addr_ok   = w_addr_ok;
    assign bus.data_ok   = w_data_ok;
    assign bus.err       = w_err;
    assign bus.rdata     = bus.rdata_axi;

    assign bus.arid      = ID_WIDTH'(RD_ID);
    assign bus.araddr    = r_addr;
    assign bus.arlen     = 8'd0;
    assign bus.arsize    = {1'b0, r_size};
    assign bus.arburst   = 2'b01;
    assign bus.arvalid   = w_arvalid;
    assign bus.rready    = w_rready;

    assign bus.awid      = ID_WIDTH'(WR_ID);
    assign bus.awaddr    = r_addr;
    assign bus.awlen     = 8'd0;
    assign bus.awsize    = {1'b0, r_size};
    assign bus.awburst   = 2'b01;
    assign bus.awvalid   = w_awvalid;
    assign bus.wdata_axi = r_wdata;
    assign bus.wstrb     = r_strb;
    assign bus.wlast     = 1'b1;
    assign bus.wvalid    = w_wvalid;
    assign bus.bready    = w_bready;

endmodule
